// File: rtl/multiplier_16_bit_seq.sv
// multiplier_16_bit_seq: sequential shift-and-add unsigned multiplier.
// One WIDTH-bit add with carry-out per RUN cycle, feeding the adder datapath
// (a, b, sum, carry-out) every cycle. Valid/ready on input and output, one
// multiplication in flight.
// Optional build macro: MUL_SKIP_ZERO_EN -- finish early once the remaining
// multiplier bits are all zero, using a barrel shift on the final RUN edge.
//
// state  | meaning
// S_IDLE | waiting for an operand pair, in_ready=1
// S_RUN  | one add/shift per edge, busy=1
// S_DONE | product held with out_valid=1 until out_ready
module multiplier_16_bit_seq #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;

   logic [WIDTH-1:0]     r_acc;
   logic [WIDTH-1:0]     r_mq;
   logic [WIDTH-1:0]     r_mcand;
   logic [CNT_W-1:0]     r_cnt;
   logic [2*WIDTH-1:0]   r_product;

   // adder datapath operands and results
   logic [WIDTH-1:0]     w_add_a;
   logic [WIDTH-1:0]     w_add_b;
   logic [WIDTH-1:0]     w_add_sum;
   logic                 w_add_cout;

   logic [2*WIDTH-1:0]   w_step;
   logic [2*WIDTH-1:0]   w_run_res;
   logic                 w_last;

   assign w_add_a = r_acc;
   assign w_add_b = r_mq[0] ? r_mcand : '0;
   assign {w_add_cout, w_add_sum} = {1'b0, w_add_a} + {1'b0, w_add_b};

   // {c, sum, mq} shifted right by one: upper half is the new acc, lower the new mq
   assign w_step = {w_add_cout, w_add_sum, r_mq[WIDTH-1:1]};

`ifdef MUL_SKIP_ZERO_EN
   // Bits of mq still to be consumed after this edge's add: positions
   // 1 .. WIDTH-1-cnt. When they are all zero the remaining iterations
   // would only shift, so shift by WIDTH-1-cnt now and finish.
   logic [WIDTH-1:0]     w_hi_bits;
   logic [CNT_W-1:0]     w_skip_sh;

   assign w_hi_bits = (r_mq >> 1) & ({WIDTH{1'b1}} >> (r_cnt + CNT_W'(1)));
   assign w_skip_sh = CNT_W'(WIDTH - 1) - r_cnt;
   assign w_last    = (w_hi_bits == '0);
   assign w_run_res = w_last ? (w_step >> w_skip_sh) : w_step;
`else
   assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_run_res = w_step;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next-state logic; a DONE transfer always returns to IDLE first
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (in_valid)  w_state_nxt = S_RUN;
         S_RUN:   if (w_last)    w_state_nxt = S_DONE;
         S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
         default:                w_state_nxt = S_IDLE;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      in_ready  = 1'b0;
      busy      = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         S_IDLE:  in_ready  = 1'b1;
         S_RUN:   busy      = 1'b1;
         S_DONE:  out_valid = 1'b1;
         default: in_ready  = 1'b0;
      endcase
   end

   // datapath: operand capture, shift-and-add iteration, product capture on entry to DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc     <= '0;
         r_mq      <= '0;
         r_mcand   <= '0;
         r_cnt     <= '0;
         r_product <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_mcand <= a;
                  r_mq    <= b;
                  r_acc   <= '0;
                  r_cnt   <= '0;
               end
            end
            S_RUN: begin
               {r_acc, r_mq} <= w_run_res;
               r_cnt         <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_product <= w_run_res;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign product = r_product;

endmodule

// File: tb/tb_multiplier_16_bit_seq.sv
// Directed bench for multiplier_16_bit_seq; expected latencies follow the
// MUL_SKIP_ZERO_EN build setting.
module tb_multiplier_16_bit_seq;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] product;
   logic        busy;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] last_prod;

`ifdef MUL_SKIP_ZERO_EN
   localparam int L_B1    = 1;
   localparam int L_B2    = 2;
   localparam int L_B5    = 3;
   localparam int L_B10   = 5;
   localparam int L_B7    = 3;
   localparam int L_B9    = 4;
   localparam int L_B0    = 1;
   localparam int L_B100  = 9;
`else
   localparam int L_B1    = 16;
   localparam int L_B2    = 16;
   localparam int L_B5    = 16;
   localparam int L_B10   = 16;
   localparam int L_B7    = 16;
   localparam int L_B9    = 16;
   localparam int L_B0    = 16;
   localparam int L_B100  = 16;
`endif
   localparam int L_FULL  = 16;

   multiplier_16_bit_seq #(.WIDTH(16), .CNT_W(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic do_mul(input logic [15:0] ta, input logic [15:0] tbv,
                         input logic [31:0] exp, input int lat, input string tag);
      int cyc;
      check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
      a = ta; b = tbv; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({tag, "_busy"}, 64'(busy), 64'(1));
      check({tag, "_hold"}, 64'(product), 64'(last_prod));
      wait_done(cyc);
      check({tag, "_latency"}, 64'(cyc), 64'(lat));
      check({tag, "_product"}, 64'(product), 64'(exp));
      last_prod = exp;
      @(posedge clk); #1;
      check({tag, "_pulse"}, 64'(out_valid), 64'(0));
      check({tag, "_ready_after"}, 64'(in_ready), 64'(1));
   endtask

   initial begin
      int cyc;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      last_prod = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_in_ready",  64'(in_ready),  64'(1));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_busy",      64'(busy),      64'(0));
      check("rst_product",   64'(product),   64'(0));

      do_mul(16'd3,    16'd5,    32'h0000_000F, L_B5,   "m3x5");
      do_mul(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, L_FULL, "mffff");
      do_mul(16'h8000, 16'h0002, 32'h0001_0000, L_B2,   "m8000x2");

      // back-pressure with operands offered while busy
      check("bp_in_ready", 64'(in_ready), 64'(1));
      a = 16'h1234; b = 16'h0010; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      a = 16'd7; b = 16'd7;
      check("bp_busy", 64'(busy), 64'(1));
      check("bp_ignored", 64'(in_ready), 64'(0));
      wait_done(cyc);
      check("bp_latency", 64'(cyc), 64'(L_B10));
      check("bp_product", 64'(product), 64'h0001_2340);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("bp_valid_held", 64'(out_valid), 64'(1));
         check("bp_product_held", 64'(product), 64'h0001_2340);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_xfer_valid", 64'(out_valid), 64'(0));
      check("bp_xfer_idle", 64'(busy), 64'(0));
      check("bp_xfer_ready", 64'(in_ready), 64'(1));
      check("bp_idle_hold", 64'(product), 64'h0001_2340);
      last_prod = 32'h0001_2340;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("m7x7_busy", 64'(busy), 64'(1));
      check("m7x7_hold", 64'(product), 64'(last_prod));
      wait_done(cyc);
      check("m7x7_latency", 64'(cyc), 64'(L_B7));
      check("m7x7_product", 64'(product), 64'd49);
      last_prod = 32'd49;
      @(posedge clk); #1;
      check("m7x7_pulse", 64'(out_valid), 64'(0));

      // reset in the middle of a run
      check("mid_in_ready", 64'(in_ready), 64'(1));
      a = 16'h00FF; b = 16'h00FF; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("mid_busy", 64'(busy), 64'(1));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid_in_ready_after", 64'(in_ready), 64'(1));
      check("mid_out_valid", 64'(out_valid), 64'(0));
      check("mid_busy_after", 64'(busy), 64'(0));
      check("mid_product", 64'(product), 64'(0));
      last_prod = '0;
      @(posedge clk); #1;
      check("mid_no_output", 64'(out_valid), 64'(0));
      do_mul(16'd2, 16'd9, 32'h0000_0012, L_B9, "m2x9");

      do_mul(16'h0000, 16'hABCD, 32'h0, L_FULL, "m0xabcd");
      do_mul(16'hABCD, 16'h0000, 32'h0, L_B0,   "mabcdx0");
      do_mul(16'd100,  16'h0001, 32'd100,   L_B1,   "m100x1");
      do_mul(16'd100,  16'h0100, 32'd25600, L_B100, "m100x256");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
